// File: rtl/if_prefetch_stage_pkg.sv
// Shared widths, bundle layouts and PC helper for the instruction-fetch prefetch stage.
package if_prefetch_stage_pkg;

  localparam int unsigned FS_PC_W       = 32;
  localparam int unsigned FS_DATA_W     = 64;
  localparam int unsigned BRANCH_DATA_W = 33;
  localparam logic [FS_PC_W-1:0] IF_RESET_PC = '0;

  typedef struct packed {
    logic [31:0]        instr;
    logic [FS_PC_W-1:0] pc;
  } fs_data_t;

  typedef struct packed {
    logic [FS_PC_W-1:0] branch_addr;
    logic               branch_control;
  } branch_data_t;

  function automatic logic [FS_PC_W-1:0] next_pc(input logic [FS_PC_W-1:0] pc);
    return pc + FS_PC_W'(4);
  endfunction

endpackage

// File: rtl/if_prefetch_fifo.sv
// DEPTH-entry circular buffer with synchronous clear; head entry is always visible.
module if_prefetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     i_clear,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_head,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_wr_ptr;
  logic [PW:0]      r_count;

  always_ff @(posedge clk) begin
    if (i_push && !i_clear) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // DEPTH is a power of two, so pointer wrap is plain overflow.
  always_ff @(posedge clk) begin
    if (i_clear) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/if_prefetch_stage.sv
// Fetch stage: credit-based SRAM read issue feeding a prefetch buffer, with zero-bubble branch redirect.
module if_prefetch_stage
  import if_prefetch_stage_pkg::*;
#(
  parameter int unsigned        DEPTH    = 4,
  parameter logic [FS_PC_W-1:0] RESET_PC = IF_RESET_PC
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fs_ds_reg_allow_in,
  output logic                       fs_to_ds_reg_valid,
  output logic [FS_DATA_W-1:0]       fs_data,
  input  logic [BRANCH_DATA_W-1:0]   branch_data,
  input  logic [31:0]                instr,
  output logic [31:0]                instr_sram_addr,
  output logic [31:0]                instr_sram_wdata,
  output logic                       instr_sram_en,
  output logic                       instr_sram_we,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  branch_data_t       w_br;
  fs_data_t           w_push_data;
  logic [FS_PC_W-1:0] r_fetch_pc;
  logic [FS_PC_W-1:0] r_req_pc;
  logic               r_inflight;
  logic               w_kill;
  logic               w_pop;
  logic               w_push;
  logic               w_credit;
  logic               w_issue;
  logic [FS_PC_W-1:0] w_issue_pc;
  logic [CW:0]        w_occ;
  logic [CW:0]        w_limit;

  assign w_br   = branch_data;
  assign w_kill = w_br.branch_control;

  assign fs_to_ds_reg_valid = (fifo_count != '0) && !w_br.branch_control;
  assign w_pop  = fs_to_ds_reg_valid && fs_ds_reg_allow_in;
  // A response landing in the branch cycle belongs to the old path.
  assign w_push = r_inflight && !w_kill;

  // Credit counts the same-cycle pop so DEPTH=2 still streams one per cycle.
  assign w_occ    = {1'b0, fifo_count} + {{CW{1'b0}}, r_inflight};
  assign w_limit  = (CW+1)'(DEPTH) + {{CW{1'b0}}, w_pop};
  assign w_credit = w_occ < w_limit;

  assign w_issue    = !reset && (w_br.branch_control || w_credit);
  assign w_issue_pc = w_br.branch_control ? w_br.branch_addr : r_fetch_pc;

  assign instr_sram_en    = w_issue;
  assign instr_sram_addr  = w_issue_pc;
  assign instr_sram_wdata = '0;
  assign instr_sram_we    = 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= RESET_PC;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_req_pc   <= w_issue_pc;
        r_fetch_pc <= next_pc(w_issue_pc);
      end
    end
  end

  assign w_push_data.instr = instr;
  assign w_push_data.pc    = r_req_pc;

  if_prefetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FS_DATA_W)
  ) u_fifo (
    .clk     (clk),
    .i_clear (reset || w_br.branch_control),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_push_data),
    .o_head  (fs_data),
    .o_count (fifo_count)
  );

endmodule
